mux_arb_n: RTL
==============

# mux_arb_n

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. It is the next generation of the team's 2:1 select mux. It adds selectable channel choice (forced select, fixed priority, or round-robin arbitration) and a one-stage output register. It sits between multiple producers (functional units, queues) and a single shared consumer (bus, writeback port) in the datapath.

## Interface
Parameters:
- `WIDTH`, 8: data width per channel, ≥1.
- `N`, 4: number of input channels, ≥2.
- `SELW`, $clog2(N): select/channel index width. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mode`  in  2  channel choice: 00 forced select, 01 fixed priority, 10 and 11 round-robin.
- `sel`  in  SELW  channel index used in mode 00.
- `in_data`  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready. Combinational; at most one bit is high.
- `out_data`  out  WIDTH  registered output data.
- `out_chan`  out  SELW  registered index of the channel that supplied `out_data`.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  consumer ready.

## Operation
- Reset (`rst_n`=0 at an edge): `out_valid`=0, `out_data`=0, `out_chan`=0, round-robin pointer `ptr`=0.
  - `in_ready` is 0 while `rst_n`=0.
  - Reset overrides any transfer in the same cycle. Held data is discarded.
- Load enable: `ld = !out_valid || out_ready`. A channel can be granted only when `ld`=1.
- Grant selection, evaluated combinationally each cycle when `ld`=1:
  - mode 00: grant `sel` if `sel`<N and `in_valid[sel]`=1. No grant if `sel`≥N.
  - mode 01: grant the lowest index k with `in_valid[k]`=1.
  - mode 1x: grant the first k with `in_valid[k]`=1, searching `ptr`, `ptr`+1, … with wrap modulo N.
- `in_ready[g]`=1 only for the granted channel g. A transfer occurs on channel g when `in_valid[g]`=1 and `in_ready[g]`=1.
- On a transfer: `out_data` ← channel g data, `out_chan` ← g, `out_valid` ← 1.
- If `ld`=1 and there is no grant: `out_valid` ← 0. `out_data` and `out_chan` hold.
- If `ld`=0: output registers hold and all `in_ready` are 0. Data stays stable while `out_valid`=1 and `out_ready`=0.
- Round-robin pointer:
  - Updates only on a transfer made in mode 1x: `ptr` ← (g+1) mod N, wrapping from N-1 to 0.
  - Transfers in modes 00 and 01 leave `ptr` unchanged.
  - `ptr` is retained across mode changes.
- `mode` and `sel` are sampled every cycle. A change affects the grant in the same cycle it is presented, because the grant is combinational.
- Simultaneous output pop and new load (`out_valid`=1, `out_ready`=1, and a grant) is a back-to-back transfer. There is no bubble.

## Timing
- Latency: input transfer at edge t makes the data visible on `out_data`/`out_valid` after edge t, one cycle.
- Throughput: one word per cycle while `out_ready`=1 and some requester is eligible.
- `in_ready` depends combinationally on `in_valid`, `mode`, `sel`, `ptr`, `out_valid` and `out_ready`. It does not depend on `in_data`.
- No combinational path from any input to `out_data`, `out_valid` or `out_chan`.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles with all `in_valid`=1 → `out_valid`=0, `out_data`=0, `in_ready`=0. After release in mode 10, the first grant goes to channel 0.
- Round-robin fairness, N=4: hold `in_valid`=4'b1111, `out_ready`=1, mode 10 → `out_chan` sequence is 0,1,2,3,0,1 with `out_valid` continuously 1. With `in_valid`=4'b1010 the sequence is 1,3,1,3.
- Fixed priority: mode 01, `in_valid`=4'b1100 → channel 2 is always granted. Then set `in_valid`=4'b1101 → channel 0 is granted next cycle, and `ptr` is unchanged.
- Forced select: mode 00 with `sel`=3 and channel 3 data 8'hA5 → `out_data`=8'hA5, `out_chan`=3 one cycle later. Then `sel`=3, `in_valid[3]`=0, `in_valid[0]`=1 → no grant and `out_valid` drops to 0.
- Back-pressure: load 8'h3C, then `out_ready`=0 for 5 cycles → `out_data` holds 8'h3C, `out_valid`=1, all `in_ready`=0. Raise `out_ready` with a requester valid → the new word appears the next cycle with no bubble.
- Reset mid-stream: with `out_valid`=1 and `ptr`=2, assert `rst_n`=0 for 1 cycle → `out_valid`=0 and `ptr`=0. The next round-robin grant with all channels valid goes to channel 0.

Source files
------------

// File: rtl/mux_arb_n.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_n
// Purpose  : N-channel, WIDTH-bit registered multiplexer with valid/ready
//            handshakes on every input and on the output. The channel is
//            chosen by forced select, fixed priority (lowest index wins), or
//            round-robin arbitration. The output passes through one register
//            stage.
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous, active-low reset
//            mode       - 00 forced select, 01 fixed priority, 1x round-robin
//            sel        - channel index used in forced-select mode
//            in_data    - channel k occupies bits [k*WIDTH +: WIDTH]
//            in_valid   - per-channel valid
//            in_ready   - per-channel ready (combinational, one-hot or zero)
//            out_data   - registered output data
//            out_chan   - registered index of the channel that supplied data
//            out_valid  - registered output valid
//            out_ready  - consumer ready
// Revision : 1.0 - initial release
// ============================================================================
module mux_arb_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [1:0] C_MODE_FORCED = 2'b00;
  localparam logic [1:0] C_MODE_PRIO   = 2'b01;

  logic [SELW-1:0]  r_ptr;
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_chan;
  logic             r_valid;

  logic             w_ld;
  logic             w_req_vld;
  logic [SELW-1:0]  w_req_idx;
  logic             w_grant;
  logic             w_hi_vld;
  logic [SELW-1:0]  w_hi_idx;
  logic             w_lo_vld;
  logic [SELW-1:0]  w_lo_idx;
  logic [WIDTH-1:0] w_gnt_data;

  // The output register may accept a new word when empty or being drained.
  assign w_ld = !r_valid || out_ready;

  // Round-robin search split into two priority scans: channels at or above
  // the pointer take precedence over those below it, which reproduces the
  // wrap-around search order without any modulo arithmetic.
  always_comb begin
    w_hi_vld = 1'b0;
    w_hi_idx = '0;
    w_lo_vld = 1'b0;
    w_lo_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        w_lo_vld = 1'b1;
        w_lo_idx = SELW'(k);
        if (SELW'(k) >= r_ptr) begin
          w_hi_vld = 1'b1;
          w_hi_idx = SELW'(k);
        end
      end
    end
  end

  // Requester selection, independent of the load/reset qualification.
  always_comb begin
    w_req_vld = 1'b0;
    w_req_idx = '0;
    case (mode)
      C_MODE_FORCED: begin
        if (int'(sel) < N) begin
          w_req_vld = in_valid[sel];
          w_req_idx = sel;
        end
      end
      C_MODE_PRIO: begin
        w_req_vld = w_lo_vld;
        w_req_idx = w_lo_idx;
      end
      default: begin
        w_req_vld = w_hi_vld || w_lo_vld;
        w_req_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
      end
    endcase
  end

  assign w_grant = rst_n && w_ld && w_req_vld;

  always_comb begin
    w_gnt_data = '0;
    for (int k = 0; k < N; k++) begin
      if (w_req_idx == SELW'(k)) begin
        w_gnt_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  generate
    for (genvar k = 0; k < N; k++) begin : g_ready
      assign in_ready[k] = w_grant && (w_req_idx == SELW'(k));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (w_ld) begin
      if (w_grant) begin
        r_valid <= 1'b1;
        r_data  <= w_gnt_data;
        r_chan  <= w_req_idx;
        // Only round-robin transfers advance the pointer.
        if (mode[1]) begin
          if (w_req_idx == SELW'(N - 1)) begin
            r_ptr <= '0;
          end else begin
            r_ptr <= w_req_idx + SELW'(1);
          end
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule
`default_nettype wire
